snitch_cluster_periph: RTL and testbench
========================================

Name: snitch_cluster_periph

Overview:
- Responder for the core data-request protocol (dreq_t in, dresp_t out) at the cluster-peripheral window, 0x4000_0000 by default.
- Holds cluster control and status registers: TCDM bounds, core count, fetch enable, scratch, wake-up, cycle counter and a software barrier counter.
- Sits on the cluster bus behind the ClusterPeripherals slave port.
- Drives fetch_enable_o and wake_up_o pulses to the cores.

Parameters:
- BaseAddr, 32'h4000_0000, base of the register window.
- NrCores, 4, number of cores; sizes fetch/wake vectors; range 1..32.
- TcdmStart, 32'h0000_0000, value returned by the TCDM start register.
- TcdmSize, 32'h1000_0000, TCDM end register returns TcdmStart+TcdmSize.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  dreq_t  request: addr, id, amo, write, data, strb
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- resp_o  out  dresp_t  response: data, id, write, error
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed when valid&ready
- fetch_enable_o  out  NrCores  per-core fetch enable
- wake_up_o  out  NrCores  per-core one-cycle wake pulse
- retired_i  in  NrCores  per-core retired-instruction strobe; used only with the optional feature

Behaviour:
- Reset values: resp_valid_o=0, resp_o='0, fetch_enable_o=0, wake_up_o=0, scratch=0, cycle=0, barrier count=0.
- Handshake:
  - req_ready_o = !resp_valid_o | resp_ready_i.
  - The request is accepted on req_valid_i & req_ready_o.
  - resp_valid_o rises the cycle after acceptance, so latency is 1 cycle.
  - resp_o is held stable while resp_valid_o & !resp_ready_i.
  - Back-to-back throughput is 1 per cycle when resp_ready_i is held high.
  - resp_o.id and resp_o.write echo the request. Write responses return data=0.
- Decode:
  - offset = addr - BaseAddr. Register index = offset[7:3]. offset[2:0] is ignored.
  - Valid offsets are 0x00..0x38. Anything else, or amo != 0, gives error=1, data=0, and no side effect.
- Registers (by offset):
  - 0x00 TCDM start, read-only (RO). Writes are ignored with error=0.
  - 0x08 TCDM end, RO. Value is TcdmStart+TcdmSize, 32-bit wrap.
  - 0x10 NrCores, RO.
  - 0x18 FetchEnable, read/write (RW). Width NrCores. Upper read bits are 0. The write updates fetch_enable_o the cycle after acceptance.
  - 0x20 Scratch, RW, 32 bits. The write honours strb byte-wise.
  - 0x28 WakeUp, write-only; read returns 0. Writing 0xFFFF_FFFF pulses all wake_up_o bits. Writing v<NrCores pulses bit v. Any other value: no pulse, error=0. The pulse lasts exactly 1 cycle, the cycle after acceptance.
  - 0x30 CycleCount, RW. Increments every cycle and wraps 0xFFFF_FFFF->0. On a write, the written value loads and beats the increment; the next cycle it reads value+1.
  - 0x38 Barrier:
    - Read returns the count before arrival, then count increments.
    - If the post-increment count equals NrCores, count clears to 0 and all wake_up_o bits pulse the next cycle.
    - With NrCores=1 every read releases.
    - A write clears count to 0 without a pulse.
- Reset asserted mid-transaction drops any pending response; there is no replay.
- Strobes are ignored on all registers except Scratch.

Optional Feature:
- Macro SNITCH_PERIPH_PERF_EN.
- Defined:
  - Adds NrCores 32-bit retired-instruction counters at offset 0x1_0000+8*i.
  - Each counter increments on retired_i[i] and wraps.
  - Reads return the counter. A write clears it; the clear beats a simultaneous increment.
  - Indices >= NrCores give error=1.
- Undefined:
  - The counter region is unmapped (error=1).
  - retired_i is unused; no counter flops exist.

Decomposition:
- snitch_pkg additions:
  - Register offset constants (PeriphOffTcdmStart..PeriphOffBarrier, PeriphOffPerf).
  - The wake-all magic 32'hFFFF_FFFF.
  - dreq_t and dresp_t are reused unchanged.
- One sub-module, snitch_periph_barrier:
  - Arrival counter of width $clog2(NrCores+1).
  - Inputs: arrive and clear strobes.
  - Outputs: count and a registered release pulse.

Test Plan:
- Reset then read 0x4000_0010 (NrCores=4) -> data=4, error=0, resp_valid 1 cycle after accept, id echoed.
- Write FetchEnable=0xF, resp_ready_i low for 3 cycles -> fetch_enable_o=4'hF from the cycle after accept. resp_o is held 3 cycles and req_ready_o is low during that time.
- Write Scratch 0xDEADBEEF with strb=4'b0101, then read -> 0x00AD00EF.
- Write CycleCount=0xFFFF_FFFE, then read 2 cycles later -> 0x0000_0000 (wrap).
- Four Barrier reads -> data 0,1,2,3. After the 4th, wake_up_o=4'hF for exactly 1 cycle and count is back to 0. WakeUp write 2 -> wake_up_o=4'b0100 for 1 cycle. WakeUp write 7 -> no pulse.
- Read 0x4000_0040, then a request with amo=4'h1 to Scratch -> both error=1, data=0, Scratch unchanged. Assert rst_ni with a response pending -> resp_valid_o=0 immediately.

Source files
------------

// File: rtl/snitch_cluster_periph_pkg.sv
// Shared types and constants for the cluster-peripheral register block.
//   dreq_t  : core data request  (addr, id, amo, write, data, strb)
//   dresp_t : core data response (data, id, write, error)
// Register offsets are relative to the peripheral window base. Each register
// occupies an 8-byte slot, and the low three offset bits are ignored.
package snitch_cluster_periph_pkg;

   localparam int unsigned IdWidth = 5;

   typedef struct packed {
      logic [31:0]        addr;
      logic [IdWidth-1:0] id;
      logic [3:0]         amo;
      logic               write;
      logic [31:0]        data;
      logic [3:0]         strb;
   } dreq_t;

   typedef struct packed {
      logic [31:0]        data;
      logic [IdWidth-1:0] id;
      logic               write;
      logic               error;
   } dresp_t;

   localparam logic [31:0] PeriphOffTcdmStart   = 32'h0000_0000;
   localparam logic [31:0] PeriphOffTcdmEnd     = 32'h0000_0008;
   localparam logic [31:0] PeriphOffNrCores     = 32'h0000_0010;
   localparam logic [31:0] PeriphOffFetchEnable = 32'h0000_0018;
   localparam logic [31:0] PeriphOffScratch     = 32'h0000_0020;
   localparam logic [31:0] PeriphOffWakeUp      = 32'h0000_0028;
   localparam logic [31:0] PeriphOffCycleCount  = 32'h0000_0030;
   localparam logic [31:0] PeriphOffBarrier     = 32'h0000_0038;
   localparam logic [31:0] PeriphOffPerf        = 32'h0001_0000;

   // A WakeUp write of this value wakes every core.
   localparam logic [31:0] WakeAllMagic = 32'hFFFF_FFFF;

   // Byte-wise write merge used by the strobed Scratch register.
   function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/snitch_cluster_periph_if.sv
// Request/response bundle between a core-side requester and the peripheral.
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; a response transfers on a rising edge where
// resp_valid_o and resp_ready_i are both high. A response stays stable
// while resp_valid_o is high and resp_ready_i is low.
//   master modport : drives req_i, req_valid_i, resp_ready_i
//   slave modport  : drives req_ready_o, resp_o, resp_valid_o
interface snitch_cluster_periph_if;
   import snitch_cluster_periph_pkg::*;

   dreq_t  req_i;
   logic   req_valid_i;
   logic   req_ready_o;
   dresp_t resp_o;
   logic   resp_valid_o;
   logic   resp_ready_i;

   modport master (
      output req_i, req_valid_i, resp_ready_i,
      input  req_ready_o, resp_o, resp_valid_o
   );

   modport slave (
      input  req_i, req_valid_i, resp_ready_i,
      output req_ready_o, resp_o, resp_valid_o
   );

endinterface

// File: rtl/snitch_cluster_periph_barrier.sv
// Software barrier arrival counter.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   arrive         : one core arrives (count increments)
//   clear          : reset the count without releasing
//   count          : arrivals so far in the current round
//   release_pulse  : one-cycle pulse, the cycle after the last core arrives
module snitch_periph_barrier #(
   parameter int unsigned NrCores = 4,
   localparam int unsigned CntW   = $clog2(NrCores + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            arrive,
   input  logic            clear,
   output logic [CntW-1:0] count,
   output logic            release_pulse
);

   logic [CntW-1:0] count_q;
   logic [CntW-1:0] count_inc;
   logic            hit_all;
   logic            release_q;

   assign count_inc = count_q + CntW'(1);
   assign hit_all   = (count_inc == CntW'(NrCores));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q   <= '0;
         release_q <= 1'b0;
      end else begin
         release_q <= arrive & ~clear & hit_all;
         if (clear) begin
            count_q <= '0;
         end else if (arrive) begin
            // The last arrival starts a fresh round.
            count_q <= hit_all ? '0 : count_inc;
         end
      end
   end

   assign count         = count_q;
   assign release_pulse = release_q;

endmodule

// File: rtl/snitch_cluster_periph.sv
// Cluster peripheral register block that responds to core data requests.
// Registers: TCDM start/end, core count, fetch enable, scratch, wake-up,
// cycle counter and software barrier. Single-cycle response latency.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   bus             : request/response bundle (slave side)
//   fetch_enable_o  : per-core fetch enable
//   wake_up_o       : per-core one-cycle wake pulse
//   retired_i       : per-core retired-instruction strobe
// Optional build macro SNITCH_PERIPH_PERF_EN adds per-core 32-bit
// retired-instruction counters at offset 0x1_0000 + 8*i. Without the macro,
// that region is unmapped and retired_i is ignored.
module snitch_cluster_periph
   import snitch_cluster_periph_pkg::*;
#(
   parameter logic [31:0] BaseAddr  = 32'h4000_0000,
   parameter int unsigned NrCores   = 4,
   parameter logic [31:0] TcdmStart = 32'h0000_0000,
   parameter logic [31:0] TcdmSize  = 32'h1000_0000
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   snitch_cluster_periph_if.slave bus,
   output logic [NrCores-1:0] fetch_enable_o,
   output logic [NrCores-1:0] wake_up_o,
   input  logic [NrCores-1:0] retired_i
);

   localparam int unsigned CntW    = $clog2(NrCores + 1);
   localparam logic [31:0] TcdmEnd = TcdmStart + TcdmSize;

   dreq_t              req;
   dresp_t             resp_q;
   logic               resp_valid_q;
   logic               req_ready;
   logic               accept;
   logic [31:0]        offset;
   logic [31:0]        reg_off;
   logic               in_regs;
   logic               perf_hit;
   logic               dec_err;
   logic               do_acc;
   logic               reg_wr;
   logic               reg_rd;
   logic [31:0]        rdata;
   logic [NrCores-1:0] fetch_q;
   logic [NrCores-1:0] wake_q;
   logic [NrCores-1:0] wake_d;
   logic [31:0]        scratch_q;
   logic [31:0]        cycle_q;
   logic [CntW-1:0]    bar_count;
   logic               bar_release;
   logic               unused_offset_bits;

   assign req = bus.req_i;

   // A new request can enter whenever the response slot is empty or is
   // being drained during this cycle.
   assign req_ready       = ~resp_valid_q | bus.resp_ready_i;
   assign bus.req_ready_o = req_ready;
   assign accept          = bus.req_valid_i & req_ready;

   // ---------------------------------------------------------------- decode
   assign offset  = req.addr - BaseAddr;
   assign in_regs = (offset[31:6] == '0);
   assign reg_off = {26'd0, offset[5:3], 3'd0};

`ifdef SNITCH_PERIPH_PERF_EN
   assign perf_hit = (offset[31:16] == PeriphOffPerf[31:16]) &&
                     (offset[15:3] < 13'(NrCores));
`else
   assign perf_hit = 1'b0;
`endif

   assign unused_offset_bits = ^offset[2:0];

   // Errored requests (bad offset or any atomic) have no side effect.
   assign dec_err = (req.amo != '0) | ~(in_regs | perf_hit);
   assign do_acc  = accept & ~dec_err;
   assign reg_wr  = do_acc & in_regs &  req.write;
   assign reg_rd  = do_acc & in_regs & ~req.write;

`ifdef SNITCH_PERIPH_PERF_EN
   logic [31:0]        perf_q [NrCores];
   logic [NrCores-1:0] perf_clr;

   always_comb begin
      perf_clr = '0;
      for (int unsigned i = 0; i < NrCores; i++) begin
         if (do_acc && perf_hit && req.write && (offset[15:3] == 13'(i))) perf_clr[i] = 1'b1;
      end
   end

   // A clear wins over a retire strobe in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NrCores; i++) perf_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NrCores; i++) begin
            if (perf_clr[i])      perf_q[i] <= '0;
            else if (retired_i[i]) perf_q[i] <= perf_q[i] + 32'd1;
         end
      end
   end
`else
   logic unused_retired;
   assign unused_retired = ^retired_i;
`endif

   // -------------------------------------------------------------- read mux
   always_comb begin
      rdata = '0;
      if (in_regs) begin
         case (reg_off)
            PeriphOffTcdmStart:   rdata = TcdmStart;
            PeriphOffTcdmEnd:     rdata = TcdmEnd;
            PeriphOffNrCores:     rdata = 32'(NrCores);
            PeriphOffFetchEnable: rdata[NrCores-1:0] = fetch_q;
            PeriphOffScratch:     rdata = scratch_q;
            // The response becomes visible one cycle after the sample, so the
            // read returns the value the counter holds at that point.
            PeriphOffCycleCount:  rdata = cycle_q + 32'd1;
            PeriphOffBarrier:     rdata[CntW-1:0] = bar_count;
            default:              rdata = '0;
         endcase
      end
`ifdef SNITCH_PERIPH_PERF_EN
      for (int unsigned i = 0; i < NrCores; i++) begin
         if (perf_hit && (offset[15:3] == 13'(i))) rdata = perf_q[i];
      end
`endif
   end

   // ----------------------------------------------------------- wake-up write
   always_comb begin
      wake_d = '0;
      if (reg_wr && (reg_off == PeriphOffWakeUp)) begin
         if (req.data == WakeAllMagic) begin
            wake_d = '1;
         end else begin
            // Values that name no core produce no pulse.
            for (int unsigned i = 0; i < NrCores; i++) begin
               if (req.data == 32'(i)) wake_d[i] = 1'b1;
            end
         end
      end
   end

   // -------------------------------------------------------------- registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_q   <= '0;
         scratch_q <= '0;
         cycle_q   <= '0;
         wake_q    <= '0;
      end else begin
         wake_q <= wake_d;
         if (reg_wr && (reg_off == PeriphOffFetchEnable)) fetch_q <= req.data[NrCores-1:0];
         if (reg_wr && (reg_off == PeriphOffScratch)) begin
            scratch_q <= strb_merge(scratch_q, req.data, req.strb);
         end
         // A software load takes priority over the free-running increment.
         if (reg_wr && (reg_off == PeriphOffCycleCount)) cycle_q <= req.data;
         else                                             cycle_q <= cycle_q + 32'd1;
      end
   end

   snitch_periph_barrier #(
      .NrCores (NrCores)
   ) i_barrier (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .arrive        (reg_rd && (reg_off == PeriphOffBarrier)),
      .clear         (reg_wr && (reg_off == PeriphOffBarrier)),
      .count         (bar_count),
      .release_pulse (bar_release)
   );

   // --------------------------------------------------------------- response
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resp_valid_q <= 1'b0;
         resp_q       <= '0;
      end else if (accept) begin
         resp_valid_q <= 1'b1;
         resp_q.data  <= (dec_err || req.write) ? 32'd0 : rdata;
         resp_q.id    <= req.id;
         resp_q.write <= req.write;
         resp_q.error <= dec_err;
      end else if (bus.resp_ready_i) begin
         resp_valid_q <= 1'b0;
      end
   end

   assign bus.resp_o       = resp_q;
   assign bus.resp_valid_o = resp_valid_q;
   assign fetch_enable_o   = fetch_q;
   assign wake_up_o        = wake_q | {NrCores{bar_release}};

endmodule

// File: tb/tb_snitch_cluster_periph.sv
// Bench for snitch_cluster_periph: directed steps followed by a randomized
// phase. A behavioural register model predicts each response, the wake pulses
// and fetch enables.
module tb_snitch_cluster_periph;
   import snitch_cluster_periph_pkg::*;

   localparam logic [31:0] BASE       = 32'h4000_0000;
   localparam int          NR         = 4;
   localparam logic [31:0] TCDM_START = 32'h0000_0000;
   localparam logic [31:0] TCDM_SIZE  = 32'h1000_0000;
   localparam int          RESP_W     = $bits(dresp_t);

   // ------------------------------------------------------ clock and reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   logic [NR-1:0] fetch_enable;
   logic [NR-1:0] wake_up;
   logic [NR-1:0] retired;

   snitch_cluster_periph_if bus();

   snitch_cluster_periph #(
      .BaseAddr  (BASE),
      .NrCores   (NR),
      .TcdmStart (TCDM_START),
      .TcdmSize  (TCDM_SIZE)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .bus            (bus),
      .fetch_enable_o (fetch_enable),
      .wake_up_o      (wake_up),
      .retired_i      (retired)
   );

   // ------------------------------------------------------------ scoreboard
   int n_vec = 0;
   int n_err = 0;
   logic [RESP_W-1:0] exp_q[$];

   // Reference model state.
   logic [NR-1:0] m_fe;
   logic [NR-1:0] m_wake;
   logic [31:0]   m_scratch;
   logic [31:0]   m_cyc_base;
   int unsigned   m_cyc_edge;
   int            m_bar;
   logic [31:0]   m_perf [NR];
   logic [NR-1:0] m_perf_clr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fe       = '0;
      m_wake     = '0;
      m_scratch  = '0;
      m_cyc_base = '0;
      m_bar      = 0;
      m_perf_clr = '0;
      for (int i = 0; i < NR; i++) m_perf[i] = '0;
   endtask

   // Predict the response of one accepted request and apply its side effects.
   // acc_edge is the clock edge at which the request is accepted.
   task automatic model_req(input logic [31:0] addr, input logic w, input logic [31:0] d,
                            input logic [3:0] strb, input logic [3:0] amo,
                            input logic [IdWidth-1:0] id, input int unsigned acc_edge);
      logic [31:0] off;
      logic [31:0] rd;
      logic        in_win;
      logic        in_perf;
      logic        err;
      int          idx;
      dresp_t      r;
      off     = addr - BASE;
      rd      = '0;
      in_win  = (off < 32'd64);
      in_perf = 1'b0;
`ifdef SNITCH_PERIPH_PERF_EN
      in_perf = (off >= 32'h1_0000) && (off < 32'h1_0000 + 32'(8 * NR));
`endif
      err = (amo != 4'd0) || !(in_win || in_perf);
      if (!err && in_win) begin
         case (off / 8)
            0: rd = TCDM_START;
            1: rd = TCDM_START + TCDM_SIZE;
            2: rd = 32'(NR);
            3: if (w) m_fe = d[NR-1:0]; else rd = 32'(m_fe);
            4: begin
               if (w) begin
                  for (int b = 0; b < 4; b++) if (strb[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
               end else begin
                  rd = m_scratch;
               end
            end
            5: begin
               if (w) begin
                  if (d == 32'hFFFF_FFFF) m_wake = '1;
                  else if (d < 32'(NR))   m_wake = NR'(32'd1 << d);
               end
            end
            6: begin
               if (w) begin
                  m_cyc_base = d;
                  m_cyc_edge = acc_edge;
               end else begin
                  rd = m_cyc_base + 32'(acc_edge - m_cyc_edge);
               end
            end
            default: begin
               if (w) begin
                  m_bar = 0;
               end else begin
                  rd    = 32'(m_bar);
                  m_bar = m_bar + 1;
                  if (m_bar == NR) begin
                     m_bar  = 0;
                     m_wake = '1;
                  end
               end
            end
         endcase
      end
      if (!err && in_perf) begin
         idx = int'((off - 32'h1_0000) >> 3);
         if (w) m_perf_clr[idx] = 1'b1;
         else   rd = m_perf[idx];
      end
      r.data  = (w || err) ? 32'd0 : rd;
      r.id    = id;
      r.write = w;
      r.error = err;
      exp_q.push_back(r);
   endtask

   // --------------------------------------------------------------- driver
   // Called at a falling edge: checks the visible outputs, drives one cycle of
   // inputs, updates the model, then advances to the next falling edge.
   task automatic step(input logic v, input logic [31:0] addr, input logic w,
                       input logic [31:0] d, input logic [3:0] strb,
                       input logic [3:0] amo, input logic rr);
      logic                rdy;
      logic [IdWidth-1:0]  id;
      chk("resp_valid", 64'(bus.resp_valid_o), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("resp", 64'(bus.resp_o), 64'(exp_q[0]));
      chk("wake_up", 64'(wake_up), 64'(m_wake));
      chk("fetch_enable", 64'(fetch_enable), 64'(m_fe));
      m_wake = '0;
      id = IdWidth'($urandom);
      bus.req_valid_i    = v;
      bus.req_i.addr     = addr;
      bus.req_i.id       = id;
      bus.req_i.amo      = amo;
      bus.req_i.write    = w;
      bus.req_i.data     = d;
      bus.req_i.strb     = strb;
      bus.resp_ready_i   = rr;
      retired            = NR'($urandom);
      #1;
      rdy = (exp_q.size() == 0) || rr;
      chk("req_ready", 64'(bus.req_ready_o), 64'(rdy));
      if (rr && exp_q.size() != 0) void'(exp_q.pop_front());
      if (v && rdy) model_req(addr, w, d, strb, amo, id, edge_cnt + 1);
`ifdef SNITCH_PERIPH_PERF_EN
      for (int i = 0; i < NR; i++) begin
         if (m_perf_clr[i]) m_perf[i] = '0;
         else               m_perf[i] = m_perf[i] + 32'(retired[i]);
      end
`endif
      m_perf_clr = '0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rd(input logic [31:0] off);
      step(1'b1, BASE + off, 1'b0, 32'd0, 4'hF, 4'd0, 1'b1);
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] strb);
      step(1'b1, BASE + off, 1'b1, d, strb, 4'd0, 1'b1);
   endtask

   task automatic idle(input logic rr);
      step(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0, rr);
   endtask

   // ------------------------------------------------------------- sequence
   initial begin
      logic [31:0] addr;
      logic [31:0] d;
      logic [3:0]  amo;
      int          sel;
      bus.req_valid_i  = 1'b0;
      bus.req_i        = '0;
      bus.resp_ready_i = 1'b0;
      retired          = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
      chk("rst_resp", 64'(bus.resp_o), 64'd0);
      chk("rst_fetch_enable", 64'(fetch_enable), 64'd0);
      chk("rst_wake_up", 64'(wake_up), 64'd0);
      rst_n      = 1'b1;
      m_cyc_edge = edge_cnt;

      // Constants and reset contents.
      rd(32'h10);
      rd(32'h00);
      rd(32'h08);
      rd(32'h20);
      rd(32'h30);
      rd(32'h38);
      rd(32'h28);

      // Fetch enable with a stalled response; a pending read waits meanwhile.
      wr(32'h18, 32'h0000_000F, 4'hF);
      repeat (3) step(1'b1, BASE + 32'h10, 1'b0, 32'd0, 4'hF, 4'd0, 1'b0);
      rd(32'h18);

      // Strobed scratch write.
      wr(32'h20, 32'hDEAD_BEEF, 4'b0101);
      rd(32'h20);

      // Cycle counter wrap.
      wr(32'h30, 32'hFFFF_FFFE, 4'hF);
      idle(1'b1);
      rd(32'h30);

      // Barrier: four arrivals release all cores, then a fresh round.
      repeat (4) rd(32'h38);
      idle(1'b1);
      rd(32'h38);
      wr(32'h38, 32'd0, 4'hF);
      rd(32'h38);

      // Wake-up writes.
      wr(32'h28, 32'd2, 4'hF);
      wr(32'h28, 32'd7, 4'hF);
      wr(32'h28, 32'hFFFF_FFFF, 4'hF);
      idle(1'b1);

      // Error cases leave scratch untouched.
      rd(32'h40);
      step(1'b1, BASE + 32'h20, 1'b1, 32'h1234_5678, 4'hF, 4'h1, 1'b1);
      rd(32'h20);
      rd(32'h1_0000);
      wr(32'h08, 32'h5555_5555, 4'hF);
      rd(32'h08);
      idle(1'b1);

      // Reset with a response pending drops it.
      step(1'b1, BASE + 32'h20, 1'b0, 32'd0, 4'hF, 4'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_drop_valid", 64'(bus.resp_valid_o), 64'd0);
      chk("rst_drop_resp", 64'(bus.resp_o), 64'd0);
      bus.req_valid_i = 1'b0;
      exp_q.delete();
      model_reset();
      @(negedge clk);
      rst_n      = 1'b1;
      m_cyc_edge = edge_cnt;
      rd(32'h20);
      rd(32'h18);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         sel = $urandom_range(0, 15);
         if (sel < 8)        addr = BASE + 32'(8 * sel) + 32'($urandom_range(0, 7));
         else if (sel < 10)  addr = BASE + 32'h1_0000 + 32'(8 * $urandom_range(0, NR + 1));
         else if (sel == 10) addr = BASE + 32'($urandom_range(64, 255));
         else if (sel == 11) addr = $urandom;
         else                addr = BASE + 32'h38;
         if ($urandom_range(0, 3) == 0)      d = 32'($urandom_range(0, 7));
         else if ($urandom_range(0, 7) == 0) d = 32'hFFFF_FFFF;
         else                                d = $urandom;
         amo = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         step($urandom_range(0, 4) != 0, addr, $urandom_range(0, 2) == 0, d,
              4'($urandom), amo, $urandom_range(0, 3) != 0);
      end
      idle(1'b1);
      idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
